// File: rtl/flash_boot_ctrl.sv
// flash_boot_ctrl: boot sequencer that issues one continuous SPI READ (0x03) at
// FLASH_OFFSET, copies BOOT_WORDS little-endian 32-bit words into memory through
// a request/ack write port, then releases the CPU reset.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_i; flash deselected, CPU held in reset
// CMD   | shifting {0x03, FLASH_OFFSET} out on MOSI, MSB first
// DATA  | clocking in one 32-bit word on MISO, bytes assembled LSB first
// WRITE | SCLK parked low, memory write held until mem_ack_i
// DONE  | image loaded, flash deselected, CPU released (terminal)
module flash_boot_ctrl #(
    parameter int          CLK_DIV      = 2,
    parameter logic [23:0] FLASH_OFFSET = 24'h100000,
    parameter int          BOOT_WORDS   = 1024,
    parameter logic [31:0] MEM_BASE     = 32'h00000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        cpu_rst_o,
    output logic        flash_cs_n,
    output logic        flash_sclk_o,
    output logic        flash_mosi_o,
    input  logic        flash_miso_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic        mem_ack_i
);

    localparam logic [15:0] DIV_LOAD = 16'(CLK_DIV - 1);
    localparam logic [15:0] WORDS    = 16'(BOOT_WORDS);
    localparam logic [31:0] CMD_WORD = {8'h03, FLASH_OFFSET};

    typedef enum logic [2:0] {IDLE, CMD, DATA, WRITE, DONE} state_t;

    state_t      state;
    logic [15:0] div_cnt;
    logic [4:0]  bit_cnt;
    logic [31:0] cmd_sh;
    logic [7:0]  byte_sh;
    logic [31:0] word_sh;
    logic [15:0] word_cnt;

    logic [7:0]  byte_nxt;
    logic [15:0] word_cnt_nxt;
    logic [31:0] addr_nxt;

    // Next-value helpers: incoming byte, incremented word count, write address.
    assign byte_nxt     = {byte_sh[6:0], flash_miso_i};
    assign word_cnt_nxt = word_cnt + 16'd1;
    assign addr_nxt     = MEM_BASE + {14'd0, word_cnt, 2'b00};

    // Sequencer: SCLK divider, command shift, data capture and memory write handshake.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            cmd_sh       <= '0;
            byte_sh      <= '0;
            word_sh      <= '0;
            word_cnt     <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            cpu_rst_o    <= 1'b1;
            flash_cs_n   <= 1'b1;
            flash_sclk_o <= 1'b0;
            flash_mosi_o <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state        <= CMD;
                        cmd_sh       <= CMD_WORD;
                        flash_mosi_o <= CMD_WORD[31];
                        bit_cnt      <= 5'd31;
                        word_cnt     <= '0;
                        div_cnt      <= DIV_LOAD;
                        flash_cs_n   <= 1'b0;
                        flash_sclk_o <= 1'b0;
                        busy_o       <= 1'b1;
                    end
                end
                CMD: begin
                    if (div_cnt == 16'd0) begin
                        div_cnt      <= DIV_LOAD;
                        flash_sclk_o <= ~flash_sclk_o;
                        // MOSI only moves on the falling edge (mode 0)
                        if (flash_sclk_o) begin
                            if (bit_cnt == 5'd0) begin
                                state        <= DATA;
                                bit_cnt      <= 5'd31;
                                flash_mosi_o <= 1'b0;
                            end else begin
                                bit_cnt      <= bit_cnt - 5'd1;
                                cmd_sh       <= {cmd_sh[30:0], 1'b0};
                                flash_mosi_o <= cmd_sh[30];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (div_cnt == 16'd0) begin
                        div_cnt      <= DIV_LOAD;
                        flash_sclk_o <= ~flash_sclk_o;
                        if (!flash_sclk_o) begin
                            byte_sh <= byte_nxt;
                            // a completed byte enters at the top, so byte 0 ends up in 7:0
                            if (bit_cnt[2:0] == 3'd0)
                                word_sh <= {byte_nxt, word_sh[31:8]};
                        end else if (bit_cnt == 5'd0) begin
                            state      <= WRITE;
                            bit_cnt    <= 5'd31;
                            mem_we_o   <= 1'b1;
                            mem_addr_o <= addr_nxt;
                            mem_data_o <= word_sh;
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                WRITE: begin
                    if (mem_ack_i) begin
                        mem_we_o <= 1'b0;
                        word_cnt <= word_cnt_nxt;
                        if (word_cnt_nxt == WORDS) begin
                            state      <= DONE;
                            flash_cs_n <= 1'b1;
                            busy_o     <= 1'b0;
                            done_o     <= 1'b1;
                            cpu_rst_o  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            div_cnt <= DIV_LOAD;
                        end
                    end
                end
                DONE: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
